// File: rtl/ker_perf_pkg.sv
// Shared constants for the kernel performance monitor: register map,
// CTRL/STATUS bit positions and the run-tracking state encoding.
package ker_perf_pkg;

    localparam logic [7:0] REG_CTRL        = 8'h00;
    localparam logic [7:0] REG_STATUS      = 8'h04;
    localparam logic [7:0] REG_LAST_CYCLES = 8'h08;
    localparam logic [7:0] REG_LAST_KC     = 8'h0C;
    localparam logic [7:0] REG_MIN_CYCLES  = 8'h10;
    localparam logic [7:0] REG_MAX_CYCLES  = 8'h14;
    localparam logic [7:0] REG_RUN_COUNT   = 8'h18;
    localparam logic [7:0] REG_TOTAL_L     = 8'h1C;
    localparam logic [7:0] REG_TOTAL_U     = 8'h20;

    localparam int CTRL_CLEAR  = 0;
    localparam int CTRL_ENABLE = 1;

    localparam int STAT_RUNNING = 0;
    localparam int STAT_SAT     = 1;
    localparam int STAT_ORPHAN  = 2;
    localparam int STAT_RESTART = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RUNNING = 1'b1
    } perf_state_e;

endpackage

// File: rtl/ker_perf_monitor_if.sv
// AXI-Lite register bus between a host and the kernel performance monitor.
interface ker_perf_monitor_if #(parameter int ADDR_W = 6);

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/ker_perf_axil_if.sv
// AXI-Lite slave for the performance monitor: handshakes, CTRL storage,
// clear / W1C strobes and the read-data mux with TOTAL_U snapshot.
module ker_perf_axil_if
    import ker_perf_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic                clk_out_PROG,
    input  logic                axi_reset_n,
    ker_perf_monitor_if.slave   s_axi,
    input  logic [3:0]          status_vec,
    input  logic [31:0]         last_cycles,
    input  logic [31:0]         last_ker_count,
    input  logic [31:0]         min_cycles,
    input  logic [31:0]         max_cycles,
    input  logic [31:0]         run_count,
    input  logic [63:0]         total,
    output logic                ctrl_enable,
    output logic                ctrl_clear,
    output logic [3:0]          status_w1c
);

    logic        awready_r;
    logic        bvalid_r;
    logic        arready_r;
    logic        rvalid_r;
    logic [31:0] rdata_r;
    logic        enable_r;
    logic [31:0] snap_u_r;
    logic        wr_fire_s;
    logic        rd_fire_s;
    logic [7:0]  waddr_s;
    logic [7:0]  raddr_s;
    logic [31:0] rd_mux_s;
    logic        unused_s;

    assign wr_fire_s = awready_r && s_axi.awvalid && s_axi.wvalid;
    assign rd_fire_s = arready_r && s_axi.arvalid;
    assign waddr_s   = 8'(s_axi.awaddr) & 8'hFC;
    assign raddr_s   = 8'(s_axi.araddr) & 8'hFC;
    assign unused_s  = ^{s_axi.wstrb, s_axi.wdata[31:4]};

    // Write channel handshake and CTRL.enable storage
    always_ff @(posedge clk_out_PROG or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            awready_r <= 1'b0;
            bvalid_r  <= 1'b0;
            enable_r  <= 1'b1;
        end else begin
            awready_r <= s_axi.awvalid && s_axi.wvalid && !bvalid_r && !awready_r;
            if (wr_fire_s) begin
                bvalid_r <= 1'b1;
            end else if (s_axi.bready) begin
                bvalid_r <= 1'b0;
            end
            if (wr_fire_s && (waddr_s == REG_CTRL)) begin
                enable_r <= s_axi.wdata[CTRL_ENABLE];
            end
        end
    end

    // Read channel handshake, data capture and TOTAL_U snapshot
    always_ff @(posedge clk_out_PROG or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0000_0000;
            snap_u_r  <= 32'h0000_0000;
        end else begin
            arready_r <= s_axi.arvalid && !rvalid_r && !arready_r;
            if (rd_fire_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_mux_s;
            end else if (s_axi.rready) begin
                rvalid_r <= 1'b0;
            end
            if (rd_fire_s && (raddr_s == REG_TOTAL_L)) begin
                snap_u_r <= total[63:32];
            end
        end
    end

    // Register read decode; unmapped offsets read as zero
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (raddr_s)
            REG_CTRL:        rd_mux_s = {30'd0, enable_r, 1'b0};
            REG_STATUS:      rd_mux_s = {28'd0, status_vec};
            REG_LAST_CYCLES: rd_mux_s = last_cycles;
            REG_LAST_KC:     rd_mux_s = last_ker_count;
            REG_MIN_CYCLES:  rd_mux_s = min_cycles;
            REG_MAX_CYCLES:  rd_mux_s = max_cycles;
            REG_RUN_COUNT:   rd_mux_s = run_count;
            REG_TOTAL_L:     rd_mux_s = total[31:0];
            REG_TOTAL_U:     rd_mux_s = snap_u_r;
            default:         rd_mux_s = 32'h0000_0000;
        endcase
    end

    assign ctrl_clear  = wr_fire_s && (waddr_s == REG_CTRL) && s_axi.wdata[CTRL_CLEAR];
    assign status_w1c  = (wr_fire_s && (waddr_s == REG_STATUS)) ? {s_axi.wdata[3:1], 1'b0} : 4'b0000;
    assign ctrl_enable = enable_r;

    assign s_axi.awready = awready_r;
    assign s_axi.wready  = awready_r;
    assign s_axi.bvalid  = bvalid_r;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = arready_r;
    assign s_axi.rvalid  = rvalid_r;
    assign s_axi.rdata   = rdata_r;
    assign s_axi.rresp   = 2'b00;

endmodule

// File: rtl/ker_perf_monitor.sv
// Kernel performance monitor: times START->DONE runs signalled over
// ker_count/ap_vld and keeps min/max/total/run statistics.
module ker_perf_monitor
    import ker_perf_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 6
) (
    input  logic                clk_out_PROG,
    input  logic                axi_reset_n,
    input  logic [31:0]         ker_count,
    input  logic                ker_count_ap_vld,
    ker_perf_monitor_if.slave   s_axi,
    output logic [31:0]         ker_active_count_L,
    output logic [31:0]         ker_active_count_U,
    output logic                run_done
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    perf_state_e      state_r, state_nx_s;
    logic [CNT_W-1:0] cyc_r, last_cycles_r, min_r, max_r, run_cnt_r, run_len_s;
    logic [31:0]      last_kc_r;
    logic [63:0]      total_r;
    logic             sat_r, orphan_r, restart_r, run_done_r;
    logic             enable_s, clear_s, start_s, done_s, valid_done_s, running_s;
    logic [3:0]       w1c_s;

    assign running_s    = (state_r == ST_RUNNING);
    assign start_s      = enable_s && ker_count_ap_vld && (ker_count == 32'd0);
    assign done_s       = enable_s && ker_count_ap_vld && (ker_count != 32'd0);
    assign valid_done_s = done_s && running_s;
    // The DONE cycle itself counts, so the run length is one past the counter.
    assign run_len_s    = (cyc_r == CNT_MAX) ? CNT_MAX : cyc_r + CNT_ONE;

    // State register
    always_ff @(posedge clk_out_PROG or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; disabling forces IDLE
    always_comb begin
        state_nx_s = state_r;
        if (!enable_s) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:    if (start_s) state_nx_s = ST_RUNNING; else state_nx_s = ST_IDLE;
                ST_RUNNING: if (done_s)  state_nx_s = ST_IDLE;    else state_nx_s = ST_RUNNING;
                default:    state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Cycle counter and sticky status flags
    always_ff @(posedge clk_out_PROG or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            cyc_r     <= CNT_ZERO;
            sat_r     <= 1'b0;
            orphan_r  <= 1'b0;
            restart_r <= 1'b0;
        end else begin
            if (start_s) begin
                cyc_r <= CNT_ZERO;
            end else if (running_s && enable_s && (cyc_r != CNT_MAX)) begin
                cyc_r <= cyc_r + CNT_ONE;
            end
            sat_r     <= (sat_r && !w1c_s[STAT_SAT]) || (running_s && enable_s && (cyc_r == CNT_MAX));
            orphan_r  <= (orphan_r && !w1c_s[STAT_ORPHAN]) || (done_s && !running_s);
            restart_r <= (restart_r && !w1c_s[STAT_RESTART]) || (start_s && running_s);
        end
    end

    // Run statistics; a same-cycle clear takes priority over DONE
    always_ff @(posedge clk_out_PROG or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            last_cycles_r <= CNT_ZERO;
            last_kc_r     <= 32'd0;
            min_r         <= CNT_MAX;
            max_r         <= CNT_ZERO;
            run_cnt_r     <= CNT_ZERO;
            total_r       <= 64'd0;
            run_done_r    <= 1'b0;
        end else if (clear_s) begin
            last_cycles_r <= CNT_ZERO;
            last_kc_r     <= 32'd0;
            min_r         <= CNT_MAX;
            max_r         <= CNT_ZERO;
            run_cnt_r     <= CNT_ZERO;
            total_r       <= 64'd0;
            run_done_r    <= 1'b0;
        end else begin
            run_done_r <= valid_done_s;
            if (done_s) begin
                last_kc_r <= ker_count;
            end
            if (valid_done_s) begin
                last_cycles_r <= run_len_s;
                run_cnt_r     <= (run_cnt_r == CNT_MAX) ? CNT_MAX : run_cnt_r + CNT_ONE;
                min_r         <= (run_len_s < min_r) ? run_len_s : min_r;
                max_r         <= (run_len_s > max_r) ? run_len_s : max_r;
                total_r       <= total_r + 64'(run_len_s);
            end
        end
    end

    assign ker_active_count_L = last_kc_r;
    assign ker_active_count_U = 32'(last_cycles_r);
    assign run_done           = run_done_r;

    ker_perf_axil_if #(.ADDR_W(ADDR_W)) u_axil (
        .clk_out_PROG   (clk_out_PROG),
        .axi_reset_n    (axi_reset_n),
        .s_axi          (s_axi),
        .status_vec     ({restart_r, orphan_r, sat_r, running_s}),
        .last_cycles    (32'(last_cycles_r)),
        .last_ker_count (last_kc_r),
        .min_cycles     (32'(min_r)),
        .max_cycles     (32'(max_r)),
        .run_count      (32'(run_cnt_r)),
        .total          (total_r),
        .ctrl_enable    (enable_s),
        .ctrl_clear     (clear_s),
        .status_w1c     (w1c_s)
    );

endmodule

// File: tb/tb_ker_perf_monitor.sv
// Directed bench for ker_perf_monitor; a second CNT_W=8 instance shares
// all stimulus so counter saturation can be observed.
module tb_ker_perf_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ker_count;
    logic        ap_vld;
    logic [31:0] l_out, u_out, l8_out, u8_out;
    logic        done_out, done8_out;
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    logic [31:0] d, d8, d0;
    logic [1:0]  rsp;

    always #5 clk = ~clk;

    ker_perf_monitor_if #(.ADDR_W(6)) bus ();
    ker_perf_monitor_if #(.ADDR_W(6)) bus8 ();

    assign bus8.awaddr  = bus.awaddr;
    assign bus8.awvalid = bus.awvalid;
    assign bus8.wdata   = bus.wdata;
    assign bus8.wstrb   = bus.wstrb;
    assign bus8.wvalid  = bus.wvalid;
    assign bus8.bready  = bus.bready;
    assign bus8.araddr  = bus.araddr;
    assign bus8.arvalid = bus.arvalid;
    assign bus8.rready  = bus.rready;

    ker_perf_monitor #(.CNT_W(32), .ADDR_W(6)) dut (
        .clk_out_PROG       (clk),
        .axi_reset_n        (rst_n),
        .ker_count          (ker_count),
        .ker_count_ap_vld   (ap_vld),
        .s_axi              (bus),
        .ker_active_count_L (l_out),
        .ker_active_count_U (u_out),
        .run_done           (done_out)
    );

    ker_perf_monitor #(.CNT_W(8), .ADDR_W(6)) dut8 (
        .clk_out_PROG       (clk),
        .axi_reset_n        (rst_n),
        .ker_count          (ker_count),
        .ker_count_ap_vld   (ap_vld),
        .s_axi              (bus8),
        .ker_active_count_L (l8_out),
        .ker_active_count_U (u8_out),
        .run_done           (done8_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle event pulse; starts and ends on a falling edge.
    task automatic ev(input logic [31:0] kc);
        ker_count = kc;
        ap_vld    = 1'b1;
        @(negedge clk);
        ap_vld    = 1'b0;
        ker_count = 32'd0;
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] rd, output logic [31:0] rd8,
                            output logic [1:0] resp);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        for (int k = 0; k < 20 && !bus.rvalid; k++) @(negedge clk);
        chk("rd_handshake", 64'(bus.rvalid), 64'd1);
        rd   = bus.rdata;
        rd8  = bus8.rdata;
        resp = bus.rresp;
        bus.arvalid = 1'b0;
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data);
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        for (int k = 0; k < 20 && !bus.bvalid; k++) @(negedge clk);
        chk("wr_handshake", 64'(bus.bvalid), 64'd1);
        chk("wr_bresp", 64'(bus.bresp), 64'd0);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] addr, input logic [31:0] exp);
        logic [31:0] v, v8;
        logic [1:0]  r;
        axi_read(addr, v, v8, r);
        chk(tag, 64'(v), 64'(exp));
    endtask

    initial begin
        rst_n = 1'b0; ker_count = 32'd0; ap_vld = 1'b0;
        bus.awaddr = 6'd0; bus.awvalid = 1'b0; bus.wdata = 32'd0; bus.wstrb = 4'h0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = 6'd0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_run_done", 64'(done_out), 64'd0);
        chk("rst_L", 64'(l_out), 64'd0);
        chk("rst_U", 64'(u_out), 64'd0);
        chk("rst_handshake", 64'({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        rd_chk("rst_ctrl", 6'h00, 32'h2);
        rd_chk("rst_min", 6'h10, 32'hFFFF_FFFF);
        rd_chk("rst_status", 6'h04, 32'h0);

        // single run of 100 cycles
        ev(32'd0);
        repeat (99) @(negedge clk);
        ev(32'h55);
        chk("r1_run_done", 64'(done_out), 64'd1);
        chk("r1_L", 64'(l_out), 64'h55);
        chk("r1_U", 64'(u_out), 64'd100);
        @(negedge clk);
        chk("r1_run_done_fall", 64'(done_out), 64'd0);
        rd_chk("r1_last", 6'h08, 32'd100);
        rd_chk("r1_lastkc", 6'h0C, 32'h55);
        rd_chk("r1_runs", 6'h18, 32'd1);
        rd_chk("r1_min", 6'h10, 32'd100);
        rd_chk("r1_max", 6'h14, 32'd100);

        // clear, then runs of 50 and 20
        axi_write(6'h00, 32'h3);
        ev(32'd0); repeat (49) @(negedge clk); ev(32'h1);
        ev(32'd0); repeat (19) @(negedge clk); ev(32'h2);
        rd_chk("r2_min", 6'h10, 32'd20);
        rd_chk("r2_max", 6'h14, 32'd50);
        rd_chk("r2_total_l", 6'h1C, 32'd70);
        rd_chk("r2_total_u", 6'h20, 32'd0);
        rd_chk("r2_runs", 6'h18, 32'd2);

        // orphan DONE
        axi_write(6'h00, 32'h3);
        ev(32'h9);
        rd_chk("orph_status", 6'h04, 32'h4);
        rd_chk("orph_runs", 6'h18, 32'd0);
        rd_chk("orph_lastkc", 6'h0C, 32'h9);
        axi_write(6'h04, 32'h4);
        rd_chk("orph_w1c", 6'h04, 32'h0);

        // restart mid-run
        ev(32'd0); repeat (29) @(negedge clk);
        ev(32'd0); repeat (39) @(negedge clk);
        ev(32'h33);
        rd_chk("rst_last", 6'h08, 32'd40);
        rd_chk("rst_status_restart", 6'h04, 32'h8);
        axi_write(6'h04, 32'h8);

        // clear accepted on the same edge as DONE
        ev(32'd0); repeat (10) @(negedge clk);
        bus.awaddr = 6'h00; bus.wdata = 32'h3; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        @(negedge clk);
        ker_count = 32'h77; ap_vld = 1'b1;
        @(negedge clk);
        ap_vld = 1'b0; ker_count = 32'd0;
        chk("clr_bvalid", 64'(bus.bvalid), 64'd1);
        chk("clr_no_run_done", 64'(done_out), 64'd0);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        bus.bready = 1'b0;
        rd_chk("clr_runs", 6'h18, 32'd0);
        rd_chk("clr_min", 6'h10, 32'hFFFF_FFFF);
        rd_chk("clr_lastkc", 6'h0C, 32'h0);
        rd_chk("clr_status", 6'h04, 32'h0);

        // disabled: events ignored
        axi_write(6'h00, 32'h0);
        ev(32'd0); repeat (5) @(negedge clk); ev(32'h44);
        rd_chk("dis_runs", 6'h18, 32'd0);
        rd_chk("dis_lastkc", 6'h0C, 32'h0);
        rd_chk("dis_ctrl", 6'h00, 32'h0);
        axi_write(6'h00, 32'h2);

        // read held with rready low
        ev(32'd0); repeat (6) @(negedge clk); ev(32'h5);
        bus.araddr = 6'h08; bus.arvalid = 1'b1; bus.rready = 1'b0;
        for (int k = 0; k < 20 && !bus.rvalid; k++) @(negedge clk);
        bus.arvalid = 1'b0;
        d0 = bus.rdata;
        chk("hold_data", 64'(d0), 64'd7);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_rvalid", 64'(bus.rvalid), 64'd1);
            chk("hold_rdata", 64'(bus.rdata), 64'd7);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        chk("hold_release", 64'(bus.rvalid), 64'd0);
        axi_read(6'h3C, d, d8, rsp);
        chk("unmapped_data", 64'(d), 64'd0);
        chk("unmapped_resp", 64'(rsp), 64'd0);

        // 300-cycle run saturates the 8-bit instance
        ev(32'd0); repeat (299) @(negedge clk); ev(32'h1);
        chk("sat_U32", 64'(u_out), 64'd300);
        chk("sat_U8", 64'(u8_out), 64'hFF);
        axi_read(6'h04, d, d8, rsp);
        chk("sat_status32", 64'(d), 64'h0);
        chk("sat_status8", 64'(d8), 64'h2);
        axi_read(6'h08, d, d8, rsp);
        chk("sat_last8", 64'(d8), 64'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
